// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - state encodings and side-select helpers for the unified-memory arbiter
package mem_port_arbiter_pkg;

   typedef logic [1:0] arb_state_t;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUSY_I  = 2'd1;
   localparam logic [1:0] ST_BUSY_D  = 2'd2;
   localparam logic [1:0] ST_DRAIN_I = 2'd3;

   localparam logic SIDE_I = 1'b0;
   localparam logic SIDE_D = 1'b1;

   // D-side wins ties unless the I-side has been starved long enough
   function automatic logic pick_side(input logic elig_i, input logic elig_d, input logic force_i);
      return (elig_i && (!elig_d || force_i)) ? SIDE_I : SIDE_D;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the port arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_cancel;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_o;

   modport slave (
      input  i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, stall_o
   );

   modport master (
      output i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, stall_o
   );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating count of consecutive I-side losses
module arb_starve_counter #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);
   localparam int W = $clog2(MAX + 1);
   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding-transaction arbiter sharing a unified memory between fetch and data
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   import mem_port_arbiter_pkg::*;

   arb_state_t        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              i_ack_q, i_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              elig_i, elig_d;
   logic              grant_i, grant_d;
   logic              starve_at_max;

   // a requester whose ack is high this cycle is finishing, not asking again
   assign elig_i = bus.i_req & ~i_ack_q;
   assign elig_d = bus.d_req & ~d_ack_q;

   arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
      .clk    (clk),
      .rst    (rst),
      .inc    (elig_i & elig_d & grant_d),
      .clr    (grant_i),
      .at_max (starve_at_max)
   );

   always_comb begin
      state_d     = state_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (elig_i || elig_d) begin
               mem_req_d = 1'b1;
               if (pick_side(elig_i, elig_d, starve_at_max) == SIDE_I) begin
                  grant_i    = 1'b1;
                  state_d    = ST_BUSY_I;
                  mem_we_d   = 1'b0;
                  mem_addr_d = bus.i_addr;
               end else begin
                  grant_d     = 1'b1;
                  state_d     = ST_BUSY_D;
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
               end
            end
         end
         ST_BUSY_I: begin
            // a redirected fetch still owns the bus until its response drains
            if (bus.i_cancel) begin
               state_d = bus.mem_rvalid ? ST_IDLE : ST_DRAIN_I;
            end else if (bus.mem_rvalid) begin
               i_rdata_d = bus.mem_rdata;
               i_ack_d   = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_BUSY_D: begin
            if (bus.mem_rvalid) begin
               if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
               d_ack_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN_I: begin
            if (bus.mem_rvalid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_ack     = i_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.stall_o   = elig_i | elig_d;

endmodule
